stream_mux_nto1: RTL and testbench
==================================

Name: stream_mux_nto1

Overview:
- Parametrised successor to the team's 2:1 combinational mux.
- Selects one of N valid/ready input streams of W-bit data and forwards it through a single registered output stage.
- Two selection modes: external select (the classic mux behaviour) or round-robin arbitration.
- Used wherever several producers share one downstream consumer.

Parameters:
- N, 4, number of input channels; legal range 2..16.
- W, 8, data width per channel; W >= 1.
- RR_MODE, 0, selection mode: 0 = channel chosen by sel port; 1 = round-robin over valid channels, sel ignored.
- SELW, derived localparam = $clog2(N), width of select and pointer.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- in_valid  input  N  per-channel valid; bit i belongs to channel i.
- in_data  input  N*W  packed data; channel i occupies bits [i*W +: W].
- in_ready  output  N  per-channel ready; at most one bit high per cycle.
- sel  input  SELW  channel select, used only when RR_MODE=0.
- out_valid  output  1  output register holds a beat.
- out_data  output  W  registered data.
- out_ready  input  1  downstream accepts the beat.

Behaviour:
- Reset values: out_valid=0, out_data=0, round-robin pointer ptr=0, in_ready=0. If rst is high, all state clears on that edge regardless of valid/ready. A beat held mid-transfer is discarded. No input handshake completes on the reset edge, because in_ready is forced to 0 while rst=1.
- load = out_ready | ~out_valid. Load is combinational, so the output register refills in the same cycle it drains.
- Grant, combinational:
  - RR_MODE=0: gnt=sel. There is no grant if sel >= N or in_valid[sel]=0.
  - RR_MODE=1: gnt is the first channel with in_valid set, searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (modulo N). There is no grant if in_valid=0.
- in_ready[gnt] = load when a grant exists. All other in_ready bits are 0.
- Transfer on channel gnt happens when in_valid[gnt] & in_ready[gnt]. On that edge: out_data <= in_data[gnt], out_valid <= 1.
- On the same edge, RR_MODE=1 only: ptr <= (gnt == N-1) ? 0 : gnt+1. Wrap-around is explicit and correct for non-power-of-2 N. ptr does not change without a transfer.
- If out_valid & out_ready and there is no transfer: out_valid <= 0, and out_data holds its old value.
- If out_valid & ~out_ready: out_valid and out_data hold. in_ready is all 0 (backpressure).
- Latency: one cycle from input handshake to out_valid. Throughput: one beat per cycle with out_ready held high.
- Fairness (RR_MODE=1): with all N channels continuously valid, each channel is granted exactly once in every N consecutive transfers.
- Changing sel while stalled is legal. The new sel takes effect on the next load cycle.
- Inputs need not hold data stable while not ready. Only the handshake cycle matters.

Optional Feature:
- Macro STREAM_MUX_CHAN_ID_EN.
- When defined:
  - Adds output port out_chan [SELW-1:0], the index of the channel whose beat currently sits in the output register.
  - out_chan is captured on the same edge as out_data, resets to 0, and holds under stall.
- When undefined: the port does not exist and no register is inferred.

Decomposition:
- Shared package stream_mux_pkg holds:
  - mode constants MUX_MODE_SEL=0 and MUX_MODE_RR=1;
  - the function clog2_min1(n), which returns at least 1 so that SELW is never 0.
- One natural sub-module: rr_pick (combinational; inputs req[N], ptr; outputs gnt and gnt_valid). It is reusable by future arbiters.
- The output register stays in the top module.

Test Plan:
- Reset and stall: assert rst for 2 cycles with in_valid=4'b1111 -> out_valid=0, out_data=0, in_ready=0. Then with out_ready=0 after one beat is loaded -> out_valid and out_data hold for 5 cycles, in_ready=0.
- Select mode: N=4, W=8, RR_MODE=0, sel=2, in_data ch2=8'hA5, out_ready=1 -> in_ready=4'b0100; out_data=8'hA5 and out_valid=1 one cycle later. With sel=3 and in_valid[3]=0 -> in_ready=0 and out_valid falls.
- Round-robin fairness: RR_MODE=1, N=4, all channels valid, channel i data = i, out_ready=1 -> out_data sequence 0,1,2,3,0,1,... over 8 cycles.
- Sparse round-robin with wrap: N=3, only ch0 and ch2 valid, ptr=0 -> grants 0,2,0,2. Pointer wraps from 2 to 0.
- Back-to-back with drain: alternate out_ready 1,0,1,1 with a continuous valid source -> no beat is lost or duplicated, and the scoreboard matches the input order.
- Macro build: compile with STREAM_MUX_CHAN_ID_EN, RR_MODE=1 -> out_chan tracks 0,1,2,3 alongside the data. Reset mid-stream -> out_chan=0 and out_valid=0 on the next cycle.

Source files
------------

// File: rtl/stream_mux_pkg.sv
// Shared constants and helpers for the N:1 stream mux family.
package stream_mux_pkg;

    localparam int unsigned MUX_MODE_SEL = 0;
    localparam int unsigned MUX_MODE_RR  = 1;

    // Select/pointer width; never 0 so that single-bit selects stay legal.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 32'd2) ? 32'd1 : 32'($clog2(n));
    endfunction

endpackage

// File: rtl/stream_mux_nto1_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr, modulo N.
module rr_pick #(
    parameter int unsigned N    = 4,
    parameter int unsigned SELW = 2
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] gnt,
    output logic            gnt_valid
);

    int unsigned idx;

    always_comb begin
        gnt       = '0;
        gnt_valid = 1'b0;
        idx       = 0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!gnt_valid && req[SELW'(idx)]) begin
                gnt       = SELW'(idx);
                gnt_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_mux_nto1.sv
// N:1 valid/ready stream mux with one registered output stage, sel or round-robin mode.
// Optional macro STREAM_MUX_CHAN_ID_EN adds out_chan (source channel of the held beat).
module stream_mux_nto1
    import stream_mux_pkg::*;
#(
    parameter  int unsigned N       = 4,
    parameter  int unsigned W       = 8,
    parameter  int unsigned RR_MODE = MUX_MODE_SEL,
    localparam int unsigned SELW    = clog2_min1(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    in_valid,
    input  logic [N*W-1:0]  in_data,
    output logic [N-1:0]    in_ready,
    input  logic [SELW-1:0] sel,
    output logic            out_valid,
    output logic [W-1:0]    out_data,
`ifdef STREAM_MUX_CHAN_ID_EN
    output logic [SELW-1:0] out_chan,
`endif
    input  logic            out_ready
);

    logic [SELW-1:0] gnt;
    logic            gnt_valid;
    logic            load_c;
    logic            xfer_c;
    logic [W-1:0]    gnt_data;
    logic            out_valid_q, out_valid_d;
    logic [W-1:0]    out_data_q, out_data_d;

    // Output register refills in the same cycle it drains.
    assign load_c = out_ready | ~out_valid_q;
    assign xfer_c = gnt_valid & load_c & ~rst;

    if (RR_MODE == MUX_MODE_RR) begin : g_rr
        logic [SELW-1:0] ptr_q, ptr_d;
        logic            unused_sel;

        assign unused_sel = ^sel;

        rr_pick #(
            .N    (N),
            .SELW (SELW)
        ) u_pick (
            .req       (in_valid),
            .ptr       (ptr_q),
            .gnt       (gnt),
            .gnt_valid (gnt_valid)
        );

        // Explicit wrap keeps the pointer in range for non-power-of-2 N.
        always_comb begin
            ptr_d = ptr_q;
            if (xfer_c) begin
                ptr_d = (gnt == SELW'(N - 1)) ? '0 : gnt + 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                ptr_q <= '0;
            end else begin
                ptr_q <= ptr_d;
            end
        end
    end else begin : g_sel
        // Out-of-range sel never matches a channel, so it yields no grant.
        always_comb begin
            gnt       = sel;
            gnt_valid = 1'b0;
            for (int unsigned i = 0; i < N; i++) begin
                if (sel == SELW'(i)) begin
                    gnt_valid = in_valid[i];
                end
            end
        end
    end

    always_comb begin
        in_ready = '0;
        gnt_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (gnt == SELW'(i)) begin
                in_ready[i] = xfer_c;
                gnt_data    = in_data[i*W +: W];
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (xfer_c) begin
            out_valid_d = 1'b1;
            out_data_d  = gnt_data;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

`ifdef STREAM_MUX_CHAN_ID_EN
    logic [SELW-1:0] chan_q, chan_d;

    always_comb begin
        chan_d = chan_q;
        if (xfer_c) begin
            chan_d = gnt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            chan_q <= '0;
        end else begin
            chan_q <= chan_d;
        end
    end

    assign out_chan = chan_q;
`else
    // No channel-id register in this build.
`endif

endmodule

// File: tb/tb_stream_mux_nto1.sv
// Directed bench: sel mode (N=4), round-robin (N=4) and sparse round-robin with wrap (N=3).
module tb_stream_mux_nto1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // DUT A: N=4, sel mode
    logic [3:0]  a_valid, a_in_ready;
    logic [31:0] a_data;
    logic [1:0]  a_sel, a_chan;
    logic        a_ov, a_or;
    logic [7:0]  a_od;
    // DUT B: N=4, round-robin
    logic [3:0]  b_valid, b_in_ready;
    logic [31:0] b_data;
    logic [1:0]  b_sel, b_chan;
    logic        b_ov, b_or;
    logic [7:0]  b_od;
    // DUT C: N=3, round-robin
    logic [2:0]  c_valid, c_in_ready;
    logic [23:0] c_data;
    logic [1:0]  c_sel, c_chan;
    logic        c_ov, c_or;
    logic [7:0]  c_od;

    stream_mux_nto1 #(.N(4), .W(8), .RR_MODE(0)) u_a (
        .clk(clk), .rst(rst), .in_valid(a_valid), .in_data(a_data), .in_ready(a_in_ready),
        .sel(a_sel), .out_valid(a_ov), .out_data(a_od),
`ifdef STREAM_MUX_CHAN_ID_EN
        .out_chan(a_chan),
`endif
        .out_ready(a_or)
    );

    stream_mux_nto1 #(.N(4), .W(8), .RR_MODE(1)) u_b (
        .clk(clk), .rst(rst), .in_valid(b_valid), .in_data(b_data), .in_ready(b_in_ready),
        .sel(b_sel), .out_valid(b_ov), .out_data(b_od),
`ifdef STREAM_MUX_CHAN_ID_EN
        .out_chan(b_chan),
`endif
        .out_ready(b_or)
    );

    stream_mux_nto1 #(.N(3), .W(8), .RR_MODE(1)) u_c (
        .clk(clk), .rst(rst), .in_valid(c_valid), .in_data(c_data), .in_ready(c_in_ready),
        .sel(c_sel), .out_valid(c_ov), .out_data(c_od),
`ifdef STREAM_MUX_CHAN_ID_EN
        .out_chan(c_chan),
`endif
        .out_ready(c_or)
    );

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] sb[$];
        logic [7:0] next_val;
        logic [3:0] rpat;
        int         accepted;
        int         drained;
        int         c_gnt[4];

        a_chan = '0; b_chan = '0; c_chan = '0;
        rst = 1'b1;
        a_valid = 4'hF; a_data = 32'h0; a_sel = 2'd0; a_or = 1'b1;
        b_valid = 4'hF; b_data = 32'h03020100; b_sel = 2'd0; b_or = 1'b1;
        c_valid = 3'b000; c_data = 24'h121110; c_sel = 2'd0; c_or = 1'b1;
        #1;
        check("rst_a_ready", 32'(a_in_ready), 32'h0);
        check("rst_b_ready", 32'(b_in_ready), 32'h0);
        tick();
        tick();
        check("rst_a_ov", 32'(a_ov), 32'h0);
        check("rst_a_od", 32'(a_od), 32'h0);
        check("rst_b_ov", 32'(b_ov), 32'h0);
        check("rst_b_od", 32'(b_od), 32'h0);
        check("rst_a_ready2", 32'(a_in_ready), 32'h0);

        // Load one beat from ch1, then stall for 5 cycles
        rst = 1'b0;
        b_valid = 4'h0;
        a_valid = 4'b0010; a_data = 32'h00003C00; a_sel = 2'd1; a_or = 1'b0;
        #1;
        check("ld_ready", 32'(a_in_ready), 32'h2);
        tick();
        check("ld_ov", 32'(a_ov), 32'h1);
        check("ld_od", 32'(a_od), 32'h3C);
`ifdef STREAM_MUX_CHAN_ID_EN
        check("ld_chan", 32'(a_chan), 32'h1);
`endif
        a_data = 32'h00007700; a_sel = 2'd2; a_valid = 4'b0110;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("stall_ready", 32'(a_in_ready), 32'h0);
            tick();
            check("stall_ov", 32'(a_ov), 32'h1);
            check("stall_od", 32'(a_od), 32'h3C);
        end

        // Select mode: sel=2 picks ch2
        a_sel = 2'd2; a_valid = 4'b0100; a_data = 32'h00A50000; a_or = 1'b1;
        #1;
        check("sel2_ready", 32'(a_in_ready), 32'h4);
        tick();
        check("sel2_ov", 32'(a_ov), 32'h1);
        check("sel2_od", 32'(a_od), 32'hA5);
`ifdef STREAM_MUX_CHAN_ID_EN
        check("sel2_chan", 32'(a_chan), 32'h2);
`endif
        a_sel = 2'd3;
        #1;
        check("sel3_ready", 32'(a_in_ready), 32'h0);
        tick();
        check("sel3_ov", 32'(a_ov), 32'h0);
        check("sel3_od", 32'(a_od), 32'hA5);

        // Back-to-back with out_ready pattern 1,0,1,1 and a scoreboard
        a_sel = 2'd0; a_valid = 4'b0001;
        rpat = 4'b1101;
        next_val = 8'h40;
        accepted = 0;
        drained = 0;
        for (int k = 0; k < 12; k++) begin
            a_or = rpat[k % 4];
            a_data[7:0] = next_val;
            #1;
            if (a_ov && a_or) begin
                drained++;
                if (sb.size() == 0) check("sb_underflow", 32'h0, 32'h1);
                else check("sb_data", 32'(a_od), 32'(sb.pop_front()));
            end
            if (a_in_ready[0]) begin
                sb.push_back(next_val);
                next_val = next_val + 8'd1;
                accepted++;
            end
            tick();
        end
        check("b2b_accepted", 32'(accepted), 32'd9);
        a_valid = 4'b0000; a_or = 1'b1;
        #1;
        if (a_ov) begin
            drained++;
            if (sb.size() == 0) check("sb_underflow", 32'h0, 32'h1);
            else check("sb_data", 32'(a_od), 32'(sb.pop_front()));
        end
        tick();
        check("b2b_drained", 32'(drained), 32'd9);
        check("b2b_sb_empty", 32'(sb.size()), 32'd0);
        check("b2b_ov", 32'(a_ov), 32'h0);

        // Round-robin fairness, all four channels valid
        b_valid = 4'hF; b_data = 32'h03020100; b_or = 1'b1;
        #1;
        check("rr_first_ready", 32'(b_in_ready), 32'h1);
        for (int k = 0; k < 8; k++) begin
            tick();
            check("rr_ov", 32'(b_ov), 32'h1);
            check("rr_od", 32'(b_od), 32'(k % 4));
`ifdef STREAM_MUX_CHAN_ID_EN
            check("rr_chan", 32'(b_chan), 32'(k % 4));
`endif
        end

        // Reset mid-stream
        tick();
        rst = 1'b1;
        #1;
        check("midrst_ready", 32'(b_in_ready), 32'h0);
        tick();
        check("midrst_ov", 32'(b_ov), 32'h0);
        check("midrst_od", 32'(b_od), 32'h0);
`ifdef STREAM_MUX_CHAN_ID_EN
        check("midrst_chan", 32'(b_chan), 32'h0);
`endif
        rst = 1'b0;
        #1;
        check("midrst_ptr0", 32'(b_in_ready), 32'h1);
        b_valid = 4'h0;

        // Sparse round-robin, N=3, ch0 and ch2 valid
        c_gnt = '{0, 2, 0, 2};
        c_valid = 3'b101; c_or = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("rr3_ready", 32'(c_in_ready), 32'h1 << c_gnt[k]);
            tick();
            check("rr3_ov", 32'(c_ov), 32'h1);
            check("rr3_od", 32'(c_od), 32'h10 + 32'(c_gnt[k]));
`ifdef STREAM_MUX_CHAN_ID_EN
            check("rr3_chan", 32'(c_chan), 32'(c_gnt[k]));
`endif
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
